// File: rtl/i2c_target_regs.sv
// I2C target exposing a byte-wide register file: pointer write, then data writes or reads.
// Pads are synchronised (2 clk), no clock stretching; local side reads combinationally and sees a wr_valid pulse per write.
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h55,
  parameter int         REG_COUNT   = 8,
  localparam int        PW          = $clog2(REG_COUNT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  input  logic [PW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          wr_valid,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
  } state_t;

  state_t        state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic [PW-1:0] ptr, ptr_n;
  logic          rw, rw_n;
  logic          sda_oe_n, busy_n, wr_en;
  logic [7:0]    regs [REG_COUNT];

  logic scl_s1, scl_s, scl_h, sda_s1, sda_s, sda_h;
  logic scl_rise, scl_fall, start, stop, rx_state;

  // Sync flops reset to the idle (released) bus level so reset exit sees no edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {scl_s1, scl_s, scl_h} <= 3'b111;
      {sda_s1, sda_s, sda_h} <= 3'b111;
    end else begin
      {scl_s1, scl_s, scl_h} <= {scl_in, scl_s1, scl_s};
      {sda_s1, sda_s, sda_h} <= {sda_in, sda_s1, sda_s};
    end
  end

  assign scl_rise = scl_s & ~scl_h;
  assign scl_fall = ~scl_s & scl_h;
  assign start    = scl_s & scl_h & sda_h & ~sda_s;
  assign stop     = scl_s & scl_h & ~sda_h & sda_s;
  assign rx_state = (state == ADDR) || (state == PTR) || (state == WDATA);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      shreg  <= '0;
      ptr    <= '0;
      rw     <= 1'b0;
      sda_oe <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      shreg  <= shreg_n;
      ptr    <= ptr_n;
      rw     <= rw_n;
      sda_oe <= sda_oe_n;
      busy   <= busy_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shreg_n  = shreg;
    ptr_n    = ptr;
    rw_n     = rw;
    sda_oe_n = sda_oe;
    busy_n   = busy;
    wr_en    = 1'b0;
    if (stop) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (start) begin
      state_n  = ADDR;
      cnt_n    = '0;
      sda_oe_n = 1'b0;
    end else begin
      if (scl_rise && rx_state) begin
        shreg_n = {shreg[6:0], sda_s};
        cnt_n   = cnt + 4'd1;
      end
      case (state)
        IDLE, WAIT_STOP: sda_oe_n = 1'b0;
        ADDR: if (scl_fall && cnt == 4'd8) begin
          cnt_n = '0;
          if (shreg[7:1] == TARGET_ADDR) begin
            sda_oe_n = 1'b1;
            busy_n   = 1'b1;
            rw_n     = shreg[0];
            state_n  = ADDR_ACK;
          end else begin
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
            state_n  = WAIT_STOP;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (rw) begin
            shreg_n  = regs[ptr];
            sda_oe_n = ~regs[ptr][7];
            cnt_n    = 4'd1;
            state_n  = RDATA;
          end else begin
            sda_oe_n = 1'b0;
            state_n  = PTR;
          end
        end
        PTR: if (scl_fall && cnt == 4'd8) begin
          ptr_n    = shreg[PW-1:0];
          cnt_n    = '0;
          sda_oe_n = 1'b1;
          state_n  = PTR_ACK;
        end
        PTR_ACK, WDATA_ACK: if (scl_fall) begin
          sda_oe_n = 1'b0;
          state_n  = WDATA;
        end
        WDATA: if (scl_fall && cnt == 4'd8) begin
          wr_en    = 1'b1;
          ptr_n    = ptr + 1'b1;
          cnt_n    = '0;
          sda_oe_n = 1'b1;
          state_n  = WDATA_ACK;
        end
        // cnt counts bits already placed on the bus; the MSB goes out on entry.
        RDATA: if (scl_fall) begin
          if (cnt == 4'd8) begin
            sda_oe_n = 1'b0;
            ptr_n    = ptr + 1'b1;
            cnt_n    = '0;
            state_n  = RACK;
          end else begin
            sda_oe_n = ~shreg[6];
            shreg_n  = {shreg[6:0], 1'b0};
            cnt_n    = cnt + 4'd1;
          end
        end
        // A NACK leaves on the rising edge, so any falling edge here follows an ACK.
        RACK: begin
          if (scl_rise && sda_s) begin
            state_n = WAIT_STOP;
          end else if (scl_fall) begin
            shreg_n  = regs[ptr];
            sda_oe_n = ~regs[ptr][7];
            cnt_n    = 4'd1;
            state_n  = RDATA;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_valid <= wr_en;
      if (wr_en) begin
        regs[ptr] <= shreg;
        wr_addr   <= ptr;
        wr_data   <= shreg;
      end
    end
  end

  assign rd_data = regs[rd_addr];

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bus-level controller, register-file model and queue-based scoreboard.
module tb_i2c_target_regs;
  localparam int         RC = 8;
  localparam int         PW = 3;
  localparam logic [6:0] TA = 7'h55;
  localparam time        Q  = 50;

  logic          clk = 1'b0, reset = 1'b0, scl = 1'b1, ctl_low = 1'b0;
  logic          sda_in, sda_oe, wr_valid, busy;
  logic [PW-1:0] rd_addr = '0, wr_addr;
  logic [7:0]    rd_data, wr_data;

  assign sda_in = ~(ctl_low | sda_oe);
  always #5 clk = ~clk;

  i2c_target_regs #(.TARGET_ADDR(TA), .REG_COUNT(RC)) dut (
    .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda_in), .sda_oe(sda_oe),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy)
  );

  typedef struct packed { logic [PW-1:0] a; logic [7:0] d; } wr_t;

  int         errors = 0, checks = 0, quiet_viol = 0;
  bit         quiet = 1'b0;
  logic [7:0] m_regs [RC];
  int         m_ptr = 0;
  logic [7:0] wbuf [4];
  wr_t        exp_wr_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] got_rd;
  wr_t        mon_e;
  event       rd_evt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Write-side monitor: every wr_valid pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (reset && wr_valid) begin
      if (exp_wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_unexpected at %0t: got addr %0d data %0h, expected no write", $time, wr_addr, wr_data);
      end else begin
        mon_e = exp_wr_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(mon_e.a));
        chk("wr_data", 32'(wr_data), 32'(mon_e.d));
      end
    end
    if (quiet && (sda_oe || busy || wr_valid)) quiet_viol++;
  end

  // Read-side monitor: every byte the controller collects must match the oldest expected byte.
  always @(rd_evt) begin
    if (exp_rd_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL rd_unexpected: got %0h, expected no read byte", got_rd);
    end else begin
      chk("rd_byte", 32'(got_rd), 32'(exp_rd_q.pop_front()));
    end
  end

  task automatic bus_start();
    ctl_low = 1'b1; #(2*Q); scl = 1'b0;
  endtask
  task automatic bus_rstart();
    #Q; ctl_low = 1'b0; #Q; scl = 1'b1; #Q; ctl_low = 1'b1; #Q; scl = 1'b0;
  endtask
  task automatic bus_stop();
    #Q; ctl_low = 1'b1; #Q; scl = 1'b1; #Q; ctl_low = 1'b0; #(2*Q);
  endtask
  task automatic bit_out(input logic b);
    #Q; ctl_low = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0;
  endtask
  task automatic bit_in(output logic b);
    #Q; ctl_low = 1'b0; #Q; scl = 1'b1; #Q; b = sda_in; #Q; scl = 1'b0;
  endtask
  task automatic byte_out(input logic [7:0] v, output logic nack);
    for (int i = 7; i >= 0; i--) bit_out(v[i]);
    bit_in(nack);
  endtask
  task automatic byte_in(output logic [7:0] v, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin bit_in(b); v[i] = b; end
    #Q; ctl_low = nack ? 1'b0 : 1'b1; #Q; scl = 1'b1; #Q;
    chk("rack_released", 32'(sda_oe), 32'd0);
    #Q; scl = 1'b0;
  endtask

  task automatic sweep_regs();
    for (int i = 0; i < RC; i++) begin
      rd_addr = PW'(i); #1;
      chk("rd_data", 32'(rd_data), 32'(m_regs[i]));
    end
  endtask

  task automatic finish_txn();
    bus_stop();
    chk("busy_after_stop", 32'(busy), 32'd0);
    sweep_regs();
  endtask

  // Address + pointer + n data bytes from wbuf; the model decides acks and register effects.
  task automatic do_write(input logic [6:0] a, input logic [7:0] p, input int n, input bit stop_after);
    logic nack;
    bit   hit = (a == TA);
    bus_start();
    byte_out({a, 1'b0}, nack);
    chk("addr_ack", 32'(nack), 32'(!hit));
    if (hit) chk("busy_on", 32'(busy), 32'd1);
    if (hit) m_ptr = p % RC;
    byte_out(p, nack);
    chk("ptr_ack", 32'(nack), 32'(!hit));
    for (int i = 0; i < n; i++) begin
      if (hit) begin
        exp_wr_q.push_back('{a: PW'(m_ptr), d: wbuf[i]});
        m_regs[m_ptr] = wbuf[i];
        m_ptr = (m_ptr + 1) % RC;
      end
      byte_out(wbuf[i], nack);
      chk("data_ack", 32'(nack), 32'(!hit));
    end
    if (stop_after) finish_txn();
  endtask

  task automatic do_read(input int n, input bit set_ptr, input logic [7:0] p);
    logic       nack;
    logic [7:0] v;
    if (set_ptr) begin
      do_write(TA, p, 0, 1'b0);
      bus_rstart();
    end else begin
      bus_start();
    end
    byte_out({TA, 1'b1}, nack);
    chk("raddr_ack", 32'(nack), 32'd0);
    chk("busy_rd", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      exp_rd_q.push_back(m_regs[m_ptr]);
      m_ptr = (m_ptr + 1) % RC;
      byte_in(v, i == n - 1);
      got_rd = v;
      ->rd_evt;
    end
    finish_txn();
  endtask

  task automatic do_mismatch(input logic [6:0] a, input int n);
    quiet = 1'b1; quiet_viol = 0;
    do_write(a, 8'($urandom), n, 1'b1);
    quiet = 1'b0;
    chk("mismatch_quiet", 32'(quiet_viol), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       nack;
    logic [6:0] a;
    for (int i = 0; i < RC; i++) m_regs[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    sweep_regs();
    reset = 1'b1;
    repeat (5) @(negedge clk);

    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    do_write(TA, 8'h02, 2, 1'b1);
    do_read(2, 1'b1, 8'h02);
    do_mismatch(7'h21, 1);
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    do_write(TA, 8'h07, 2, 1'b1);
    wbuf[0] = 8'h9D;
    do_write(TA, 8'h06, 1, 1'b1);
    do_write(TA, 8'hF6, 0, 1'b1);
    do_read(1, 1'b0, 8'h00);
    do_read(1, 1'b0, 8'h00);

    // Reset in the middle of the address ACK.
    bus_start();
    for (int i = 7; i >= 0; i--) bit_out(((8'hAA) >> i) & 1'b1);
    for (int k = 0; k < 20 && !sda_oe; k++) @(negedge clk);
    chk("oe_before_reset", 32'(sda_oe), 32'd1);
    reset = 1'b0; #1;
    chk("oe_at_reset", 32'(sda_oe), 32'd0);
    chk("busy_at_reset", 32'(busy), 32'd0);
    for (int i = 0; i < RC; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    sweep_regs();
    ctl_low = 1'b0; #Q; scl = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #(2*Q);
    wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
    do_write(TA, 8'h01, 2, 1'b1);

    for (int t = 0; t < 20; t++) begin
      case ($urandom_range(0, 3))
        0: begin
          for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
          do_write(TA, 8'($urandom), $urandom_range(0, 3), 1'b1);
        end
        1: do_read($urandom_range(1, 3), 1'b0, 8'h00);
        2: do_read($urandom_range(1, 3), 1'b1, 8'($urandom));
        default: begin
          a = 7'($urandom_range(0, 127));
          if (a == TA) a = a ^ 7'h01;
          do_mismatch(a, $urandom_range(0, 2));
        end
      endcase
    end

    repeat (10) @(negedge clk);
    chk("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    chk("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- Synthesizable I2C target (responder) that answers the SoC I2C controller on the shared open-drain SCL/SDA bus. It replaces the behavioural bus model used on the bench.
- Exposes a small byte-wide register file. The bus controller writes and reads it with a pointer-then-data protocol.
- Local logic reads the register file through a side port and sees a strobe for every accepted write.

Parameters:
- TARGET_ADDR, 7'h55, 7-bit I2C address this block responds to.
- REG_COUNT, 8, number of 8-bit registers; power of 2; pointer width PW = log2(REG_COUNT).

Ports:
- clk  in  1  system clock; SCL high and low phases each last at least 4 clk cycles.
- reset  in  1  asynchronous, active-low reset.
- scl_in  in  1  SCL pad input, asynchronous.
- sda_in  in  1  SDA pad input, asynchronous.
- sda_oe  out  1  1 = pull SDA low; 0 = release. The block never drives SCL and does not clock-stretch.
- rd_addr  in  PW  local read index.
- rd_data  out  8  regs[rd_addr], combinational.
- wr_valid  out  1  one-cycle pulse when a bus write updates a register.
- wr_addr  out  PW  index written, valid with wr_valid.
- wr_data  out  8  byte written, valid with wr_valid.
- busy  out  1  high from START to STOP when addressed.

Behaviour:
- Input synchronisation
  - scl_in and sda_in each pass through 2 flops, then 1 history flop.
  - All edge and condition detection uses the synchronised signals, so latency is 2 clk from pad to sync.
- Bus conditions
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
  - START from any state, including a repeated start, clears the bit counter and enters ADDR. sda_oe is released that same cycle.
  - STOP from any state returns to IDLE and releases sda_oe.
- Sampling and driving
  - Bits are sampled on the detected SCL rising edge, MSB first.
  - sda_oe changes only in the cycle the SCL falling edge is detected.
- States:
  - IDLE: waits for START.
  - ADDR: shift 8 bits (7 address + R/W). On the 8th falling edge:
    - If the address equals TARGET_ADDR: drive ACK, set busy, then go to ADDR_ACK.
    - Otherwise go to WAIT_STOP with sda_oe=0.
  - ADDR_ACK: release SDA on the next falling edge.
    - R/W=0: go to PTR.
    - R/W=1: load shift register with regs[ptr], drive the MSB (sda_oe = ~bit), go to RDATA.
  - PTR: receive 8 bits. On the 8th falling edge: ptr <= byte[PW-1:0] (upper bits ignored), drive ACK, go to PTR_ACK.
  - PTR_ACK: release on the next falling edge, then go to WDATA.
  - WDATA: receive 8 bits. On the 8th falling edge:
    - regs[ptr] <= byte.
    - Pulse wr_valid with wr_addr=ptr and wr_data=byte.
    - ptr <= ptr+1, wrapping modulo REG_COUNT.
    - Drive ACK, go to WDATA_ACK.
  - WDATA_ACK: release on the next falling edge, then go to WDATA.
  - RDATA: shift out on each falling edge. After the 8th bit's falling edge:
    - Release SDA.
    - ptr <= ptr+1, wrapping.
    - Go to RACK.
  - RACK: sample the controller's ack on the rising edge.
    - 0 (ACK): on the falling edge load regs[ptr], drive the MSB, go to RDATA.
    - 1 (NACK): go to WAIT_STOP.
  - WAIT_STOP: sda_oe=0; wait for STOP or START.
- ptr persists across transactions. A read without a preceding pointer write continues from the last ptr.
- Simultaneous local read and bus write to the same index: rd_data shows the new value from the cycle after the write.
- busy clears on STOP, and on address mismatch after a repeated start.
- Reset values, applied immediately and asynchronously:
  - State IDLE, sda_oe=0, busy=0, wr_valid=0, wr_addr=0, wr_data=0.
  - ptr=0, all regs=0, bit counter=0.
  - Reset mid-transfer releases SDA at once. The block re-syncs on the next START.

Test Plan:
- Write burst: START, 0xAA (0x55, W), 0x02, 0xA5, 0x3C, STOP.
  - ACK on all 4 bytes.
  - wr_valid pulses twice: (2, 0xA5) then (3, 0x3C).
  - rd_addr=3 gives rd_data=0x3C.
  - busy is 0 after STOP.
- Read with repeated start: write ptr 0x02, repeated START, 0xAB, read 2 bytes (ACK, then NACK), STOP.
  - Bytes returned are 0xA5 then 0x3C.
  - ptr=4 afterwards.
  - Block releases SDA during the NACK bit.
- Address mismatch: START, 0x42, 1 data byte, STOP.
  - sda_oe stays 0 throughout, busy stays 0, no wr_valid, regs unchanged.
- Pointer wrap: ptr 0x07, write 0x11, 0x22.
  - regs[7]=0x11 and regs[0]=0x22.
  - wr_addr sequence is 7, 0.
- Reset mid-transfer: assert reset while sda_oe=1 during an ACK.
  - sda_oe=0 in the same cycle, regs=0.
  - After deassertion, a new write transaction succeeds.
- Pointer-only write then read: write ptr 0x06 and STOP, then START, 0xAB, read 1 byte, NACK.
  - Returns regs[6].
  - No wr_valid during the pointer write.
